// File: rtl/alu_exec_unit_if.sv
// Request/result bundle between the ALU-control stage, the execution unit and writeback.
// Request side: in_valid/selec/a/b; result side: out_valid/result/zero/illegal.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    // Handshake: a transfer happens on a rising edge where valid && ready. The sender keeps
    // valid and payload stable until that edge, and the receiver ignores payload while valid is low.
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       selec;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, selec, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, selec, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execution unit: single-cycle add/sub/or/and/slt and a WIDTH-cycle shift-add unsigned multiply.
// The result is held in a register until the downstream stage accepts it.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave io_bus,
    output logic [1:0]     o_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_illegal;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_last;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_acc_next;

    assign io_bus.in_ready  = (r_state == S_IDLE);
    assign io_bus.out_valid = (r_state == S_DONE);
    assign io_bus.result    = r_result;
    assign io_bus.zero      = (r_result == '0);
    assign io_bus.illegal   = r_illegal;
    assign o_state          = r_state;

    assign w_accept   = io_bus.in_valid && io_bus.in_ready;
    assign w_is_mul   = (io_bus.selec == 4'd5);
    assign w_last     = (r_count == CW'(WIDTH - 1));
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_alu_res = '0;
        case (io_bus.selec)
            4'd0:    w_alu_res = io_bus.a + io_bus.b;
            4'd1:    w_alu_res = io_bus.a - io_bus.b;
            4'd2:    w_alu_res = io_bus.a | io_bus.b;
            4'd3:    w_alu_res = io_bus.a & io_bus.b;
            4'd4:    w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(io_bus.a) < $signed(io_bus.b))};
            default: w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_is_mul ? S_MUL : S_DONE;
            S_MUL:   if (w_last) w_next = S_DONE;
            // No accept in the consume cycle: in_ready only rises once back in IDLE.
            S_DONE:  if (io_bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_illegal <= (io_bus.selec > 4'd5);
                        if (w_is_mul) begin
                            r_mcand  <= io_bus.a;
                            r_mplier <= io_bus.b;
                            r_acc    <= '0;
                            r_count  <= '0;
                        end else begin
                            r_result <= w_alu_res;
                        end
                    end
                end
                S_MUL: begin
                    // Fixed WIDTH iterations; bits shifted out of the multiplicand are the truncated high half.
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (w_last) r_result <= w_acc_next;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU select code produced by the ALU control decoder.
- Accepts a select code plus two operands through a valid/ready handshake and computes add/sub/or/and/slt in one cycle, or an iterative unsigned multiply over WIDTH cycles.
- Holds the registered result until the downstream stage accepts it.
- Sits between the decode/ALU-control stage and the writeback path of the multicycle datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (>=4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request.
- selec  input  4  operation code: 0 add, 1 sub, 2 or, 3 and, 4 slt, 5 mul; 6-15 illegal.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- illegal  output  1  accepted selec was 6-15.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, result=0, zero=1, illegal=0; multiply counter and accumulators cleared.
  - Reset mid-multiply or mid-hold aborts the operation; nothing is replayed.
- States: IDLE, MUL, DONE. in_ready is 1 only in IDLE. out_valid is 1 only in DONE.
- Accept: a request is accepted when in_valid && in_ready on a clock edge. a, b and selec are captured at that edge; later input changes are ignored.
- IDLE with accept, selec 0-4 or 6-15: result computed and registered at the same edge; next state DONE. out_valid is high the cycle after acceptance (latency 1).
  - 0 add: (a+b) mod 2^WIDTH, carry discarded.
  - 1 sub: (a-b) mod 2^WIDTH.
  - 2 or: a|b.
  - 3 and: a&b.
  - 4 slt: signed two's-complement compare; result = {WIDTH-1 zeros, (a<b)}.
  - 6-15: result=0, illegal=1. For all legal codes, illegal=0.
- IDLE with accept, selec=5: load multiplicand=a, multiplier=b, acc=0, count=0; next state MUL.
- MUL, each cycle:
  - If multiplier LSB=1, acc += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; count++.
  - After WIDTH iterations, result = acc (low WIDTH bits of the unsigned product) and state goes to DONE.
  - out_valid is first high WIDTH+1 cycles after the accept edge.
  - No early termination on a zero multiplier; latency is fixed.
- DONE:
  - result, zero and illegal are held stable while out_valid=1 && out_ready=0.
  - On out_ready=1: state goes to IDLE and out_valid drops on that edge; result, zero and illegal keep their last values.
  - The unit does not accept a new request in the same cycle the result is consumed; the next accept is possible one cycle later (in IDLE).
- zero is updated together with result (combinational compare of the registered result, or registered alongside it; it must be consistent with result whenever out_valid=1).
- in_valid while in_ready=0 has no effect; the requester must hold its request.

Test Plan:
- After reset, in_valid=1, selec=0, a=32'hFFFFFFFF, b=1 -> one cycle later out_valid=1, result=0, zero=1, illegal=0; out_ready=1 -> next cycle out_valid=0, in_ready=1.
- selec=4, a=32'hFFFFFFFE (-2), b=3 -> result=1. Then selec=4, a=3, b=32'hFFFFFFFE -> result=0, zero=1. Then selec=1, a=5, b=7 -> result=32'hFFFFFFFE.
- selec=5, a=1234, b=5678 -> out_valid exactly 33 cycles after accept, result=7006652. selec=5, a=32'h10000, b=32'h10000 -> result=0, zero=1 (truncation).
- Backpressure: selec=2, a=32'hF0, b=32'h0F; hold out_ready=0 for 10 cycles -> result=32'hFF stable, in_ready=0 throughout. Also toggle a, b and in_valid during the hold -> no effect on result.
- selec=9, a=7, b=7 -> result=0, illegal=1, zero=1. Next selec=3, a=32'hFF, b=32'h0F -> illegal=0, result=32'h0F.
- Start selec=5 and assert rst_n=0 at cycle 10 of MUL -> out_valid=0, in_ready=1, result=0 immediately (asynchronous). After release, selec=0, a=2, b=3 -> result=5.
